// File: rtl/dbus_pkg.sv
// Shared widths and FSM state type for the data-bus SRAM slave.
package dbus_pkg;

    localparam int unsigned DBUS_MASK   = 4;
    localparam int unsigned DBUS_ADDR_W = 32;
    localparam int unsigned DBUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dbus_state_e;

endpackage

// File: rtl/dbus_sram_array.sv
// Single-port word array: synchronous read, per-byte write enable, no reset on contents.
module dbus_sram_array
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DBUS_DATA_W-1:0]         wdata,
    input  logic [DBUS_MASK-1:0]           be,
    output logic [DBUS_DATA_W-1:0]         rdata
);

    logic [DBUS_DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DBUS_DATA_W-1:0] rdata_q;

    // Byte-masked write or registered word read, only when enabled
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < int'(DBUS_MASK); i++) begin
                    if (be[i]) begin
                        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dbus_sram_slave.sv
// Data-bus SRAM slave: fixed-latency request/response around dbus_sram_array.
// Optional macro DBUS_SLV_ADDR_CHECK_EN: out-of-window accesses respond with O_err
// and touch nothing; otherwise addresses wrap modulo the array size.
module dbus_sram_slave
    import dbus_pkg::*;
#(
    parameter logic [DBUS_ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned            DEPTH_WORDS = 4096,
    parameter int unsigned            WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   I_req,
    input  logic                   I_we,
    input  logic [DBUS_ADDR_W-1:0] I_addr,
    input  logic [DBUS_DATA_W-1:0] I_data,
    input  logic [DBUS_MASK-1:0]   I_mask,
    output logic [DBUS_DATA_W-1:0] O_data,
    output logic                   O_ready,
    output logic                   O_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned SPAN_W    = DBUS_ADDR_W + 1;
    localparam logic [SPAN_W-1:0] SPAN = SPAN_W'(DEPTH_WORDS) << 2;
    // WAIT_CYCLES=0 bypasses WAIT, so the init value is only meaningful for >= 1
    localparam logic [3:0] WAIT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dbus_state_e state_q, state_d;
    logic [3:0]             cnt_q;
    logic                   we_q;
    logic                   err_q;
    logic [AW-1:0]          idx_q;
    logic [DBUS_DATA_W-1:0] data_q;
    logic [DBUS_MASK-1:0]   mask_q;

    logic [DBUS_ADDR_W-1:0] off;
    logic [AW-1:0]          req_idx;
    logic                   req_err;
    logic                   unused_off;

    logic                   acc_go;
    logic                   acc_en;
    logic                   acc_we;
    logic                   acc_err;
    logic [AW-1:0]          acc_idx;
    logic [DBUS_DATA_W-1:0] acc_data;
    logic [DBUS_MASK-1:0]   acc_mask;
    logic [DBUS_DATA_W-1:0] arr_rdata;

    // BASE_ADDR is word aligned, so addr[1:0] never reaches the index or the range test
    assign off     = I_addr - BASE_ADDR;
    assign req_idx = off[AW+1:2];

`ifdef DBUS_SLV_ADDR_CHECK_EN
    assign req_err    = (SPAN_W'(off) >= SPAN);
    assign unused_off = ^off[1:0];
`else
    assign req_err    = 1'b0;
    assign unused_off = ^{off[DBUS_ADDR_W-1:AW+2], off[1:0]};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (I_req) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and wait counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 4'd0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else if (state_q == IDLE && I_req) begin
            cnt_q  <= WAIT_INIT;
            we_q   <= I_we;
            err_q  <= req_err;
            idx_q  <= req_idx;
            data_q <= I_data;
            mask_q <= I_mask;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Array access happens on the edge that enters RESP; zero-wait requests use live inputs
    always_comb begin
        acc_go = (state_d == RESP) && (state_q != RESP);
        if (state_q == IDLE) begin
            acc_we   = I_we;
            acc_err  = req_err;
            acc_idx  = req_idx;
            acc_data = I_data;
            acc_mask = I_mask;
        end else begin
            acc_we   = we_q;
            acc_err  = err_q;
            acc_idx  = idx_q;
            acc_data = data_q;
            acc_mask = mask_q;
        end
        // A reset on the commit edge abandons the access
        acc_en = acc_go && rst && !acc_err;
    end

    dbus_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .en   (acc_en),
        .we   (acc_we),
        .addr (acc_idx),
        .wdata(acc_data),
        .be   (acc_mask),
        .rdata(arr_rdata)
    );

    // Response outputs, all qualified by RESP
    always_comb begin
        O_ready = (state_q == RESP);
`ifdef DBUS_SLV_ADDR_CHECK_EN
        O_err   = (state_q == RESP) && err_q;
`else
        O_err   = 1'b0;
`endif
        O_data  = (state_q == RESP && !we_q && !err_q) ? arr_rdata : '0;
    end

endmodule

// File: tb/tb_dbus_sram_slave.sv
// Scoreboard bench for dbus_sram_slave: driver pushes expected responses from a
// word-array reference model, a negedge monitor pops and compares on O_ready.
module tb_dbus_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned WAITC = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT (WAIT_CYCLES=2)
    logic        I_req, I_we;
    logic [31:0] I_addr, I_data;
    logic [3:0]  I_mask;
    logic [31:0] O_data;
    logic        O_ready, O_err;

    // Zero-wait DUT
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  mask0;
    logic [31:0] rdata0;
    logic        ready0, err0;

    dbus_sram_slave #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .I_req  (I_req),
        .I_we   (I_we),
        .I_addr (I_addr),
        .I_data (I_data),
        .I_mask (I_mask),
        .O_data (O_data),
        .O_ready(O_ready),
        .O_err  (O_err)
    );

    dbus_sram_slave #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(16),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clk    (clk),
        .rst    (rst),
        .I_req  (req0),
        .I_we   (we0),
        .I_addr (addr0),
        .I_data (wdata0),
        .I_mask (mask0),
        .O_data (rdata0),
        .O_ready(ready0),
        .O_err  (err0)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem [DEPTH];

    function automatic bit model_err(input logic [31:0] addr);
`ifdef DBUS_SLV_ADDR_CHECK_EN
        return !(addr >= BASE && addr < BASE + 32'(4 * DEPTH));
`else
        return (addr === 32'hx);
`endif
    endfunction

    function automatic int unsigned model_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off / 4) % DEPTH;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (O_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ready: got O_ready=1, expected no response (cycle %0d)",
                             cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_data", O_data, mon_e.data);
                    check("resp_err", {31'b0, O_err}, {31'b0, mon_e.err});
                    check("resp_latency", cyc, mon_e.cyc);
                end
            end else begin
                check("idle_data", O_data, 32'h0);
            end
        end
    end

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input bit drop);
        exp_t        e;
        logic [31:0] w;
        int unsigned idx;
        int          n;
        @(negedge clk);
        idx   = model_idx(addr);
        e.err = model_err(addr);
        e.cyc = cyc + 1 + WAITC;
        if (we) begin
            e.data = 32'h0;
            if (!e.err) begin
                w = model_mem[idx];
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
                end
                model_mem[idx] = w;
            end
        end else begin
            e.data = e.err ? 32'h0 : model_mem[idx];
        end
        sb_q.push_back(e);
        I_req  = 1'b1;
        I_we   = we;
        I_addr = addr;
        I_data = data;
        I_mask = mask;
        @(negedge clk);
        if (drop) I_req = 1'b0;
        n = 0;
        while (O_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL response_timeout: got no O_ready in 40 cycles, expected one");
            sb_q.delete();
        end
        I_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        rst    = 1'b0;
        I_req  = 1'b0;
        I_we   = 1'b0;
        I_addr = 32'h0;
        I_data = 32'h0;
        I_mask = 4'h0;
        req0   = 1'b0;
        we0    = 1'b0;
        addr0  = BASE;
        wdata0 = 32'h0;
        mask0  = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, O_ready}, 32'h0);
        check("reset_err", {31'b0, O_err}, 32'h0);
        check("reset_data", O_data, 32'h0);
        rst = 1'b1;

        // Give every word a known value
        for (int i = 0; i < int'(DEPTH); i++) txn(1'b1, BASE + 32'(4 * i), $urandom(), 4'hF, 1'b0);

        // Full write and readback
        txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0);

        // Partial byte mask over a known pattern
        txn(1'b1, 32'h8000_0040, 32'hAAAA_AAAA, 4'hF, 1'b0);
        txn(1'b1, 32'h8000_0040, 32'h1122_3344, 4'b0101, 1'b0);
        txn(1'b0, 32'h8000_0043, 32'h0, 4'h0, 1'b0);

        // Empty mask leaves the word alone
        txn(1'b1, 32'h8000_0010, 32'h0BAD_F00D, 4'h0, 1'b0);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 1'b0);

        // Request dropped after acceptance still commits
        txn(1'b1, 32'h8000_0030, 32'hCAFE_0123, 4'hF, 1'b1);
        txn(1'b0, 32'h8000_0030, 32'h0, 4'h0, 1'b0);

        // Reset one cycle after a write is accepted abandons it
        @(negedge clk);
        I_req  = 1'b1;
        I_we   = 1'b1;
        I_addr = 32'h8000_0020;
        I_data = 32'h5A5A_5A5A;
        I_mask = 4'hF;
        @(negedge clk);
        rst   = 1'b0;
        I_req = 1'b0;
        @(negedge clk);
        check("rst_wait_ready", {31'b0, O_ready}, 32'h0);
        check("rst_wait_data", O_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, 1'b0);

        // Out-of-window accesses: error response or wrap, as the model decides
        txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b0);
        txn(1'b1, BASE + 32'(4 * DEPTH), 32'h1357_9BDF, 4'hF, 1'b0);
        txn(1'b0, BASE, 32'h0, 4'h0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom();
            else a = BASE + 32'(4 * $urandom_range(0, DEPTH + 7)) + 32'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0));
        end

        // Zero-wait slave with a read held high: ready alternates
        @(negedge clk);
        req0 = 1'b1;
        we0  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("b2b_ready", {31'b0, ready0}, (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        req0 = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dbus_sram_slave.md
DBUS_SRAM_SLAVE -- requirements
Module: dbus_sram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, meaning number of 32-bit words; power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before the response; range 0..15.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port I_req  input  1  initiator request; held high with fields stable until O_ready is sampled high.
REQ-007 SHALL have port I_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port I_addr  input  32  byte address; bits [1:0] are ignored.
REQ-009 SHALL have port I_data  input  32  write data.
REQ-010 SHALL have port I_mask  input  4  byte enables for writes; bit i enables byte i.
REQ-011 SHALL have port O_data  output  32  read data; valid only while O_ready=1 for a read.
REQ-012 SHALL have port O_ready  output  1  single-cycle response strobe.
REQ-013 SHALL have port O_err  output  1  error flag, qualified by O_ready.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 In IDLE with I_req=1, the block SHALL latch we/addr/data/mask. It SHALL go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES=0.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP at the edge on which the counter is 0.
REQ-017 The array access SHALL occur on the edge that enters RESP: masked byte write, or registered word read.
REQ-018 RESP SHALL assert O_ready=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: request sampled at edge N gives O_ready high during cycle N+1+WAIT_CYCLES.
REQ-020 Requests SHALL NOT be accepted in WAIT or RESP. A request still high in IDLE after RESP SHALL be treated as a new transaction.
REQ-021 Once a request is latched, deassertion of I_req SHALL NOT abort it; the access and the O_ready pulse still occur.
REQ-022 A write with I_mask=4'b0000 SHALL complete the handshake and modify no bytes.
REQ-023 O_data SHALL be 0 outside RESP and during write responses.
REQ-024 Word index SHALL be (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.

Reset
REQ-025 rst=0 at a clock edge SHALL force IDLE, counter=0, O_ready=0, O_err=0 and O_data=0.
REQ-026 Reset during WAIT SHALL abandon the transaction: no write commits and no O_ready pulse.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro DBUS_SLV_ADDR_CHECK_EN defined, an address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL complete with O_ready=1 and O_err=1. Such a write SHALL modify nothing and such a read SHALL return O_data=0.
REQ-029 Without DBUS_SLV_ADDR_CHECK_EN, addresses SHALL wrap modulo the array size and O_err SHALL be tied to 0.

Structure
REQ-030 Package dbus_pkg SHALL hold DBUS_MASK=4, 32-bit address/data widths and the FSM state enum (IDLE/WAIT/RESP).
REQ-031 The storage SHALL be a sub-module dbus_sram_array: single port, synchronous read, per-byte write enable.
REQ-032 dbus_sram_slave SHALL contain only the FSM, wait counter, request latch, address check and output registers.

Verification
REQ-033 Scenario: write 32'hDEAD_BEEF, mask 4'hF, to 32'h8000_0010, then read it back -> each O_ready exactly 3 cycles after req sampled (WAIT_CYCLES=2); read O_data=32'hDEAD_BEEF.
REQ-034 Scenario: write 32'h1122_3344, mask 4'b0101, over a word holding 32'hAAAA_AAAA -> readback 32'hAA22_AA44.
REQ-035 Scenario: WAIT_CYCLES=0 with back-to-back reads held on I_req -> O_ready every second cycle, alternating 1,0,1,0.
REQ-036 Scenario: rst=0 asserted one cycle after a write to 32'h8000_0020 is accepted -> no O_ready; readback after reset returns the prior contents.
REQ-037 Scenario: with DBUS_SLV_ADDR_CHECK_EN, read 32'h7FFF_FFFC -> O_ready=1, O_err=1, O_data=0. Without the macro, write to BASE_ADDR+4*DEPTH_WORDS -> word 0 updated, O_err=0.
REQ-038 Scenario: I_req dropped in the cycle after a write is accepted -> write still committed and O_ready still pulses once.
